despejo_de_registradores: RTL and testbench
===========================================

// Module: despejo_de_registradores
// PURPOSE
//  Debug read-out engine for the 32x32 register bank. On request it freezes the core,
//  walks the bank through one combinational read port and streams each (index, value)
//  pair out on a valid/ready interface. It consumes the bank's read side, complementing
//  the core's writeback path, and replaces ad-hoc single-register debug taps.
// PARAMETERS
//  DATA_W     32  register width
//  ADDR_W     5   register index width
//  FIRST_REG  0   first index dumped
//  LAST_REG   31  last index dumped; FIRST_REG <= LAST_REG < 2**ADDR_W required
// PORTS
//  clock      in   1       system clock, all state on rising edge
//  reset      in   1       synchronous, active-high
//  dump_start in   1       1-cycle request to begin a dump
//  halt_req   out  1       ask core to stop retiring (no bank writes while high)
//  halt_ack   in   1       core confirms it is frozen
//  rd_addr    out  ADDR_W  bank read-port index
//  rd_data    in   DATA_W  bank read-port data, combinational from rd_addr
//  out_valid  out  1       out_index/out_data hold a beat
//  out_ready  in   1       sink accepts beat when out_valid & out_ready
//  out_index  out  ADDR_W  register index of current beat
//  out_data   out  DATA_W  register value of current beat
//  busy       out  1       high from dump_start accept until DONE exits
//  done       out  1       1-cycle pulse after last beat accepted
// BEHAVIOUR
//  Reset: state IDLE; halt_req=0, out_valid=0, busy=0, done=0, out_index=0,
//   out_data=0, internal idx=FIRST_REG; rd_addr=FIRST_REG.
//  rd_addr = idx at all times (combinational from register).
//  FSM:
//   IDLE:     dump_start=1 -> WAIT_ACK, halt_req<=1, busy<=1, idx<=FIRST_REG.
//   WAIT_ACK: halt_ack=1 -> READ; else stay (no timeout). halt_ack already high on
//             entry still needs one cycle in WAIT_ACK.
//   READ:     capture out_data<=rd_data, out_index<=idx, out_valid<=1 -> SEND.
//   SEND:     hold out_* stable while out_valid & ~out_ready.
//             On handshake: out_valid<=0; idx==LAST_REG -> DONE, else idx<=idx+1 -> READ.
//   DONE:     done<=1 for exactly one cycle, halt_req<=0, busy<=0 -> IDLE.
//  Throughput: 2 cycles/register with out_ready tied high; full 32-reg dump =
//   1 (WAIT_ACK w/ ack) + 64 + 1 (DONE) cycles after dump_start.
//  halt_ack only sampled in WAIT_ACK; deasserting it later is ignored (core contract:
//   hold frozen while halt_req=1). Bank writes occur on falling edge; with core frozen,
//   rd_data is stable at the READ rising edge.
//  dump_start while busy=1 (incl. DONE cycle) is ignored, not queued.
//  out_ready while out_valid=0 is ignored; no beat is ever dropped or duplicated.
//  idx never exceeds LAST_REG; no wrap-around. FIRST_REG==LAST_REG -> exactly one beat.
//  reset mid-dump: next cycle IDLE, out_valid=0, halt_req=0, done=0, no pending beat.
// TESTING
//  1 Bank preloaded r[i]=i*0x11111111, halt_ack follows halt_req 1 cycle later,
//    out_ready=1, pulse dump_start -> 32 beats index 0..31 with matching data,
//    done pulse once, halt_req low after DONE, total 67 cycles start-to-done.
//  2 Same, out_ready random 30% duty -> identical 32-beat sequence, out_* stable
//    during every stall, no beat duplicated or skipped.
//  3 halt_ack held low 10 cycles -> no out_valid, halt_req=1 throughout, dump then
//    proceeds normally when ack rises.
//  4 dump_start pulsed again at beats 5 and during DONE -> ignored, single done pulse.
//  5 reset asserted while SEND holds index 12 -> next cycle out_valid=0, halt_req=0,
//    busy=0; fresh dump_start restarts at index 0.
//  6 FIRST_REG=LAST_REG=29, r[29]=0xDEADBEEF -> exactly one beat (29, 0xDEADBEEF), done.

Source files
------------

// File: rtl/despejo_de_registradores.sv
// Debug dump engine: freezes the core, then streams every (index, value) pair of the register bank.
// Latency: 2 cycles per register after halt_ack plus one DONE cycle; done pulses once per dump.
// Backpressure: a beat is held stable in SEND until out_ready; the bank walk stalls with it.
module despejo_de_registradores #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dump_start,
    output logic              halt_req,
    input  logic              halt_ack,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_index,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LAST_REG);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ACK,
        READ,
        SEND,
        DONE
    } state_t;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   idx, idx_nx;
    logic                halt_nx, busy_nx, done_nx, valid_nx;
    logic [ADDR_W-1:0]   index_nx;
    logic [DATA_W-1:0]   data_nx;

    assign rd_addr = idx;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= FIRST_IDX;
            halt_req  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_index <= '0;
            out_data  <= '0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            halt_req  <= halt_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            out_valid <= valid_nx;
            out_index <= index_nx;
            out_data  <= data_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        halt_nx  = halt_req;
        busy_nx  = busy;
        done_nx  = 1'b0;
        valid_nx = out_valid;
        index_nx = out_index;
        data_nx  = out_data;
        case (state)
            IDLE: begin
                if (dump_start) begin
                    state_nx = WAIT_ACK;
                    halt_nx  = 1'b1;
                    busy_nx  = 1'b1;
                    idx_nx   = FIRST_IDX;
                end
            end
            WAIT_ACK: begin
                if (halt_ack) begin
                    state_nx = READ;
                end
            end
            READ: begin
                data_nx  = rd_data;
                index_nx = idx;
                valid_nx = 1'b1;
                state_nx = SEND;
            end
            SEND: begin
                // out_valid is always high here, so out_ready alone completes the beat
                if (out_ready) begin
                    valid_nx = 1'b0;
                    if (idx == LAST_IDX) begin
                        state_nx = DONE;
                    end else begin
                        idx_nx   = idx + ADDR_W'(1);
                        state_nx = READ;
                    end
                end
            end
            DONE: begin
                done_nx  = 1'b1;
                halt_nx  = 1'b0;
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_despejo_de_registradores.sv
// Bench for the register dump engine: full-range instance plus a single-register instance.
module tb_despejo_de_registradores;

    logic        clock;
    logic        reset;
    logic        dump_start, halt_req, halt_ack, out_valid, out_ready, busy, done;
    logic [4:0]  rd_addr, out_index;
    logic [31:0] rd_data, out_data;

    logic        dump_start2, halt_req2, halt_ack2, out_valid2, out_ready2, busy2, done2;
    logic [4:0]  rd_addr2, out_index2;
    logic [31:0] rd_data2, out_data2;

    logic [31:0] bank [0:31];
    logic        ack_en, hr_seen, hr2_seen;

    int total;
    int bad;

    logic [4:0]  got_idx [$];
    logic [31:0] got_dat [$];

    despejo_de_registradores dut (
        .clock(clock), .reset(reset), .dump_start(dump_start),
        .halt_req(halt_req), .halt_ack(halt_ack),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .out_data(out_data),
        .busy(busy), .done(done)
    );

    despejo_de_registradores #(.FIRST_REG(29), .LAST_REG(29)) dut2 (
        .clock(clock), .reset(reset), .dump_start(dump_start2),
        .halt_req(halt_req2), .halt_ack(halt_ack2),
        .rd_addr(rd_addr2), .rd_data(rd_data2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_index(out_index2), .out_data(out_data2),
        .busy(busy2), .done(done2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign rd_data  = bank[rd_addr];
    assign rd_data2 = bank[rd_addr2];

    // Core model: acknowledges halt_req one cycle after it is seen
    always @(negedge clock) begin
        halt_ack  = ack_en & hr_seen;
        hr_seen   = halt_req;
        halt_ack2 = hr2_seen;
        hr2_seen  = halt_req2;
    end

    task automatic start_dump();
        @(negedge clock);
        dump_start = 1'b1;
        @(negedge clock);
        dump_start = 1'b0;
    endtask

    // Drives out_ready and records accepted beats; returns raw observations only
    task automatic run_sink(input int ready_pct, input bit inject, input int max_cyc,
                            output int nbeats, output int done_cnt, output int done_at,
                            output int stall_bad, output bit timeout);
        bit          prev_stall = 1'b0;
        bit          seen_done  = 1'b0;
        bit          inj_pending = 1'b0;
        int          post = 0;
        logic [4:0]  pi = '0;
        logic [31:0] pd = '0;
        got_idx.delete();
        got_dat.delete();
        nbeats = 0; done_cnt = 0; done_at = -1; stall_bad = 0; timeout = 1'b1;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            if (cyc > 1) @(negedge clock);
            dump_start = 1'b0;
            if (inj_pending) begin
                dump_start  = 1'b1;
                inj_pending = 1'b0;
            end
            if (prev_stall && (out_valid !== 1'b1 || out_index !== pi || out_data !== pd))
                stall_bad++;
            if (done === 1'b1) begin
                done_cnt++;
                if (!seen_done) done_at = cyc - 1;
                seen_done = 1'b1;
            end
            out_ready  = ($urandom_range(0, 99) < ready_pct);
            prev_stall = out_valid && !out_ready;
            pi = out_index;
            pd = out_data;
            if (out_valid && out_ready) begin
                got_idx.push_back(out_index);
                got_dat.push_back(out_data);
                nbeats++;
                if (inject && nbeats == 5) dump_start = 1'b1;
                if (inject && out_index == 5'd31) inj_pending = 1'b1;
            end
            if (seen_done) begin
                post++;
                if (post > 3) begin
                    timeout = 1'b0;
                    break;
                end
            end
        end
        out_ready  = 1'b0;
        dump_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        total++;
        if ({halt_req, out_valid, busy, done} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=0000", {halt_req, out_valid, busy, done});
        end
        total++;
        if (out_index !== 5'd0 || out_data !== 32'd0) begin
            bad++;
            $display("FAIL reset_out got=%0d/%h want=0/00000000", out_index, out_data);
        end
        total++;
        if (rd_addr !== 5'd0) begin
            bad++;
            $display("FAIL reset_rd_addr got=%0d want=0", rd_addr);
        end
        total++;
        if (rd_addr2 !== 5'd29) begin
            bad++;
            $display("FAIL reset_rd_addr2 got=%0d want=29", rd_addr2);
        end
    endtask

    task automatic check_sequence(input string name, input int nbeats);
        total++;
        if (nbeats != 32) begin
            bad++;
            $display("FAIL %s_beats got=%0d want=32", name, nbeats);
        end
        for (int i = 0; i < nbeats && i < 32; i++) begin
            logic [31:0] want;
            want = i * 32'h11111111;
            total++;
            if (got_idx[i] !== 5'(i) || got_dat[i] !== want) begin
                bad++;
                $display("FAIL %s_beat%0d got=%0d/%h want=%0d/%h", name, i, got_idx[i], got_dat[i], i, want);
            end
        end
    endtask

    task automatic test_full_dump();
        int nb, dc, da, sb;
        bit to;
        start_dump();
        run_sink(100, 1'b0, 400, nb, dc, da, sb, to);
        total++;
        if (to !== 1'b0) begin bad++; $display("FAIL full_timeout got=%0d want=0", to); end
        check_sequence("full", nb);
        total++;
        if (dc != 1) begin bad++; $display("FAIL full_done_cnt got=%0d want=1", dc); end
        total++;
        if (da != 67) begin bad++; $display("FAIL full_latency got=%0d want=67", da); end
        total++;
        if (halt_req !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL full_release got=%b%b want=00", halt_req, busy);
        end
    endtask

    task automatic test_backpressure();
        int nb, dc, da, sb;
        bit to;
        start_dump();
        run_sink(30, 1'b0, 3000, nb, dc, da, sb, to);
        total++;
        if (to !== 1'b0) begin bad++; $display("FAIL bp_timeout got=%0d want=0", to); end
        check_sequence("bp", nb);
        total++;
        if (sb != 0) begin bad++; $display("FAIL bp_stall_stable got=%0d want=0", sb); end
        total++;
        if (dc != 1) begin bad++; $display("FAIL bp_done_cnt got=%0d want=1", dc); end
    endtask

    task automatic test_ack_delay();
        int nb, dc, da, sb;
        int hold_bad = 0;
        bit to;
        ack_en = 1'b0;
        start_dump();
        repeat (10) begin
            @(negedge clock);
            if (out_valid !== 1'b0 || halt_req !== 1'b1) hold_bad++;
        end
        total++;
        if (hold_bad != 0) begin
            bad++;
            $display("FAIL ack_wait_hold got=%0d want=0", hold_bad);
        end
        ack_en = 1'b1;
        run_sink(100, 1'b0, 400, nb, dc, da, sb, to);
        total++;
        if (to !== 1'b0) begin bad++; $display("FAIL ack_timeout got=%0d want=0", to); end
        check_sequence("ack", nb);
        total++;
        if (dc != 1) begin bad++; $display("FAIL ack_done_cnt got=%0d want=1", dc); end
    endtask

    task automatic test_ignore_start();
        int nb, dc, da, sb;
        bit to;
        start_dump();
        run_sink(100, 1'b1, 400, nb, dc, da, sb, to);
        total++;
        if (to !== 1'b0) begin bad++; $display("FAIL ign_timeout got=%0d want=0", to); end
        check_sequence("ign", nb);
        total++;
        if (dc != 1) begin bad++; $display("FAIL ign_done_cnt got=%0d want=1", dc); end
        total++;
        if (busy !== 1'b0 || halt_req !== 1'b0) begin
            bad++;
            $display("FAIL ign_no_restart got=%b%b want=00", busy, halt_req);
        end
    endtask

    task automatic test_reset_mid_dump();
        int nb, dc, da, sb;
        bit to;
        bit found = 1'b0;
        start_dump();
        for (int c = 0; c < 200; c++) begin
            if (out_valid === 1'b1 && out_index === 5'd12) begin
                out_ready = 1'b0;
                reset     = 1'b1;
                found     = 1'b1;
                break;
            end
            out_ready = 1'b1;
            @(negedge clock);
        end
        total++;
        if (!found) begin bad++; $display("FAIL mid_reach12 got=0 want=1"); end
        @(negedge clock);
        total++;
        if ({out_valid, halt_req, busy, done} !== 4'b0000) begin
            bad++;
            $display("FAIL mid_reset_state got=%b want=0000", {out_valid, halt_req, busy, done});
        end
        total++;
        if (rd_addr !== 5'd0) begin bad++; $display("FAIL mid_rd_addr got=%0d want=0", rd_addr); end
        reset = 1'b0;
        repeat (3) @(negedge clock);
        start_dump();
        run_sink(100, 1'b0, 400, nb, dc, da, sb, to);
        total++;
        if (to !== 1'b0) begin bad++; $display("FAIL mid_timeout got=%0d want=0", to); end
        check_sequence("mid", nb);
        total++;
        if (dc != 1) begin bad++; $display("FAIL mid_done_cnt got=%0d want=1", dc); end
    endtask

    task automatic test_single_reg();
        int nb = 0, dc = 0, post = 0;
        logic [4:0]  gi = '0;
        logic [31:0] gd = '0;
        bank[29] = 32'hDEADBEEF;
        @(negedge clock);
        dump_start2 = 1'b1;
        @(negedge clock);
        dump_start2 = 1'b0;
        out_ready2  = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (out_valid2 === 1'b1) begin
                gi = out_index2;
                gd = out_data2;
                nb++;
            end
            if (done2 === 1'b1) dc++;
            if (dc > 0) post++;
            if (post > 3) break;
            @(negedge clock);
        end
        out_ready2 = 1'b0;
        total++;
        if (nb != 1) begin bad++; $display("FAIL single_beats got=%0d want=1", nb); end
        total++;
        if (gi !== 5'd29 || gd !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL single_beat got=%0d/%h want=29/deadbeef", gi, gd);
        end
        total++;
        if (dc != 1) begin bad++; $display("FAIL single_done_cnt got=%0d want=1", dc); end
        total++;
        if (busy2 !== 1'b0 || halt_req2 !== 1'b0) begin
            bad++;
            $display("FAIL single_release got=%b%b want=00", busy2, halt_req2);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 32; i++) bank[i] = i * 32'h11111111;
        reset       = 1'b1;
        dump_start  = 1'b0;
        dump_start2 = 1'b0;
        out_ready   = 1'b0;
        out_ready2  = 1'b0;
        ack_en      = 1'b1;
        hr_seen     = 1'b0;
        hr2_seen    = 1'b0;
        halt_ack    = 1'b0;
        halt_ack2   = 1'b0;

        test_reset();
        test_full_dump();
        test_backpressure();
        test_ack_delay();
        test_ignore_start();
        test_reset_mid_dump();
        test_single_reg();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
